// File: rtl/sram_c_arb.sv
// Two-requester round-robin arbiter in front of single-port SRAM C.
// Optional power-up clear sweep enabled by defining SRAM_C_ARB_CLEAR_EN.
module sram_c_arb (
    input  logic       rpll_clk,
    input  logic       rst,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [9:0] r0_addr,
    input  logic [7:0] r0_din,
    output logic       r0_gnt,
    output logic       r0_rvalid,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [9:0] r1_addr,
    input  logic [7:0] r1_din,
    output logic       r1_gnt,
    output logic       r1_rvalid,
    output logic [7:0] rd_data,
    output logic       sram_C_we,
    output logic [9:0] sram_C_addr,
    output logic [7:0] sram_C_din,
    input  logic [7:0] sram_C_dout,
    output logic       init_done
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    localparam logic [0:0] ST_RUN   = 1'b1;
`ifdef SRAM_C_ARB_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [0:0] ST_RESET = ST_RUN;
`endif

    logic [0:0]    state_q, state_d;
    logic          last_q, last_d;      // 1: requester 1 won the last accepted transfer
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
`ifdef SRAM_C_ARB_CLEAR_EN
    logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

    always_ff @(posedge rpll_clk) begin
        if (rst) begin
            state_q    <= ST_RESET;
            last_q     <= 1'b1;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
`ifdef SRAM_C_ARB_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
`ifdef SRAM_C_ARB_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    // Next-state, grant and SRAM port steering; idle cycles replay the last address/data.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rv0_d       = 1'b0;
        rv1_d       = 1'b0;
        done_d      = (state_q == ST_RUN);
        addr_d      = addr_q;
        din_d       = din_q;
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        sram_C_we   = 1'b0;
        sram_C_addr = addr_q;
        sram_C_din  = din_q;
`ifdef SRAM_C_ARB_CLEAR_EN
        clr_addr_d  = clr_addr_q;
`endif
        if (rst) begin
            sram_C_addr = '0;
            sram_C_din  = '0;
        end
`ifdef SRAM_C_ARB_CLEAR_EN
        else if (state_q == ST_CLEAR) begin
            sram_C_we   = 1'b1;
            sram_C_addr = clr_addr_q;
            sram_C_din  = '0;
            addr_d      = clr_addr_q;
            din_d       = '0;
            clr_addr_d  = clr_addr_q + AW'(1);
            if (&clr_addr_q) begin
                state_d = ST_RUN;
            end
        end
`endif
        else begin
            r0_gnt = r0_req & (~r1_req | last_q);
            r1_gnt = r1_req & (~r0_req | ~last_q);
            if (r0_gnt) begin
                sram_C_we   = r0_we;
                sram_C_addr = r0_addr;
                sram_C_din  = r0_din;
                addr_d      = r0_addr;
                din_d       = r0_din;
                last_d      = 1'b0;
                rv0_d       = ~r0_we;
            end else if (r1_gnt) begin
                sram_C_we   = r1_we;
                sram_C_addr = r1_addr;
                sram_C_din  = r1_din;
                addr_d      = r1_addr;
                din_d       = r1_din;
                last_d      = 1'b1;
                rv1_d       = ~r1_we;
            end
        end
    end

    // Registered status is masked while reset is held so every output reads 0.
    assign r0_rvalid = rv0_q & ~rst;
    assign r1_rvalid = rv1_q & ~rst;
    assign init_done = done_q & ~rst;
    assign rd_data   = (r0_rvalid | r1_rvalid) ? sram_C_dout : '0;

endmodule

// File: tb/tb_sram_c_arb.sv
// Directed bench for sram_c_arb with a behavioural SRAM C; clear-sweep
// scenarios are included when SRAM_C_ARB_CLEAR_EN is defined.
module tb_sram_c_arb;

    logic       rpll_clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_req = 1'b0, r0_we = 1'b0;
    logic [9:0] r0_addr = '0;
    logic [7:0] r0_din = '0;
    logic       r0_gnt, r0_rvalid;
    logic       r1_req = 1'b0, r1_we = 1'b0;
    logic [9:0] r1_addr = '0;
    logic [7:0] r1_din = '0;
    logic       r1_gnt, r1_rvalid;
    logic [7:0] rd_data;
    logic       sram_C_we;
    logic [9:0] sram_C_addr;
    logic [7:0] sram_C_din;
    logic [7:0] sram_C_dout;
    logic       init_done;
    logic       mem_init = 1'b0;
    logic [7:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    // Initial SRAM pattern is mem[i] = i*7+3; the clear sweep zeroes it.
`ifdef SRAM_C_ARB_CLEAR_EN
    localparam logic [7:0] EXP0    = 8'h00;
    localparam logic [7:0] EXP1023 = 8'h00;
`else
    localparam logic [7:0] EXP0    = 8'h03;
    localparam logic [7:0] EXP1023 = 8'hFC;
`endif

    sram_c_arb dut (
        .rpll_clk(rpll_clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_din(r0_din),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_din(r1_din),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rd_data(rd_data),
        .sram_C_we(sram_C_we), .sram_C_addr(sram_C_addr), .sram_C_din(sram_C_din),
        .sram_C_dout(sram_C_dout), .init_done(init_done)
    );

    always #5 rpll_clk = ~rpll_clk;

    always @(posedge rpll_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (sram_C_we) begin
            mem[sram_C_addr] <= sram_C_din;
        end
        sram_C_dout <= mem[sram_C_addr];
    end

    task automatic step();
        @(posedge rpll_clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_done !== 1'b1 && n < 2100) begin
            step();
            n++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_wait init_done=%b after %0d cycles, expected 1", init_done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h155; r0_din = 8'hAA;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd5;
        step(); mem_init = 1'b0; step(); step();
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, sram_C_we, init_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b expected 000000",
                     {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, sram_C_we, init_done});
        end
        checks++;
        if ({sram_C_addr, sram_C_din, rd_data} !== 26'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h din=%h rd=%h expected all 0", sram_C_addr, sram_C_din, rd_data);
        end
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; rst = 1'b0;
        wait_init();
    endtask

    task automatic test_round_robin();
        logic [1:0] eg, erv;
        logic [7:0] erd;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd1023;
        for (int i = 0; i < 4; i++) begin
            #1;
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({r0_gnt, r1_gnt} !== eg || sram_C_addr !== ((i % 2 == 0) ? 10'd0 : 10'd1023)) begin
                errors++;
                $display("FAIL rr_grant[%0d] gnt=%b addr=%0d expected gnt=%b", i, {r0_gnt, r1_gnt}, sram_C_addr, eg);
            end
            if (i > 0) begin
                erv = (i % 2 == 0) ? 2'b01 : 2'b10;
                erd = (i % 2 == 0) ? EXP1023 : EXP0;
                checks++;
                if ({r0_rvalid, r1_rvalid} !== erv || rd_data !== erd) begin
                    errors++;
                    $display("FAIL rr_rvalid[%0d] rv=%b rd=%h expected rv=%b rd=%h",
                             i, {r0_rvalid, r1_rvalid}, rd_data, erv, erd);
                end
            end
            step();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 4'b0001 || rd_data !== EXP1023) begin
            errors++;
            $display("FAIL rr_tail gnt/rv=%b rd=%h expected 0001 rd=%h", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, rd_data, EXP1023);
        end
        step();
        checks++;
        if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rr_single_pulse rv=%b expected 00", {r0_rvalid, r1_rvalid});
        end
    endtask

    task automatic test_write_read();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd0; r0_din = 8'hCC;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt, sram_C_we} !== 3'b101 || sram_C_addr !== 10'd0 || sram_C_din !== 8'hCC) begin
            errors++;
            $display("FAIL wr_grant gnt/we=%b addr=%h din=%h expected 101 addr=0 din=cc",
                     {r0_gnt, r1_gnt, sram_C_we}, sram_C_addr, sram_C_din);
        end
        step();
        r0_we = 1'b0;
        #1;
        checks++;
        if ({r0_gnt, sram_C_we, r0_rvalid, r1_rvalid} !== 4'b1000) begin
            errors++;
            $display("FAIL rd_grant gnt/we/rv=%b expected 1000", {r0_gnt, sram_C_we, r0_rvalid, r1_rvalid});
        end
        step();
        r0_req = 1'b0;
        #1;
        checks++;
        if ({r0_gnt, r0_rvalid, r1_rvalid} !== 3'b010 || rd_data !== 8'hCC) begin
            errors++;
            $display("FAIL rd_data gnt/rv=%b rd=%h expected 010 rd=cc", {r0_gnt, r0_rvalid, r1_rvalid}, rd_data);
        end
        step();
        checks++;
        if (r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse r0_rvalid=%b expected 0", r0_rvalid);
        end
    endtask

    task automatic test_boundary();
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd1023; r1_din = 8'h5A;
        #1;
        checks++;
        if ({r1_gnt, sram_C_we} !== 2'b11 || sram_C_addr !== 10'd1023) begin
            errors++;
            $display("FAIL bnd_wr gnt/we=%b addr=%0d expected 11 addr=1023", {r1_gnt, sram_C_we}, sram_C_addr);
        end
        step();
        r1_we = 1'b0;
        step();
        r1_req = 1'b0;
        #1;
        checks++;
        if ({r1_rvalid, r0_rvalid} !== 2'b10 || rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL bnd_rd rv=%b rd=%h expected 10 rd=5a", {r1_rvalid, r0_rvalid}, rd_data);
        end
        checks++;
        if (sram_C_we !== 1'b0 || sram_C_addr !== 10'd1023 || sram_C_din !== 8'h5A) begin
            errors++;
            $display("FAIL idle_hold we=%b addr=%0d din=%h expected we=0 addr=1023 din=5a", sram_C_we, sram_C_addr, sram_C_din);
        end
    endtask

    task automatic test_idle_no_update();
        r0_req = 1'b1; r0_addr = 10'd7; r0_we = 1'b0;
        r1_req = 1'b1; r1_addr = 10'd9; r1_we = 1'b0;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL idle_pre gnt=%b expected 10", {r0_gnt, r1_gnt});
        end
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        step(); step(); step();
        r0_req = 1'b1; r1_req = 1'b1;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL idle_post gnt=%b expected 01", {r0_gnt, r1_gnt});
        end
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd0;
        #1;
        checks++;
        if (r0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant r0_gnt=%b expected 1", r0_gnt);
        end
        step();
        rst = 1'b1; r0_req = 1'b0;
        #1;
        checks++;
        if (r0_rvalid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_cancel r0_rvalid=%b rd=%h expected 0 00", r0_rvalid, rd_data);
        end
        step();
        checks++;
        if (r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_cancel2 r0_rvalid=%b expected 0", r0_rvalid);
        end
        rst = 1'b0;
        wait_init();
        r0_req = 1'b1; r0_addr = 10'd1023;
        r1_req = 1'b1; r1_addr = 10'd0; r1_we = 1'b0;
        #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL mid_prio gnt=%b expected 10", {r0_gnt, r1_gnt});
        end
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        #1;
        checks++;
`ifdef SRAM_C_ARB_CLEAR_EN
        if (r0_rvalid !== 1'b1 || rd_data !== 8'h00) begin
`else
        if (r0_rvalid !== 1'b1 || rd_data !== 8'h5A) begin
`endif
            errors++;
            $display("FAIL mid_read r0_rvalid=%b rd=%h", r0_rvalid, rd_data);
        end
        step();
    endtask

`ifdef SRAM_C_ARB_CLEAR_EN
    task automatic test_clear_sweep();
        int bad = 0;
        rst = 1'b1; r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd517; r1_req = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (r0_gnt !== 1'b0 || sram_C_we !== 1'b1 || sram_C_addr !== 10'(i) ||
                sram_C_din !== 8'h00 || init_done !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clr_sweep bad_cycles=%0d expected 0", bad);
        end
        #1;
        checks++;
        if ({r0_gnt, init_done} !== 2'b10) begin
            errors++;
            $display("FAIL clr_run gnt/done=%b expected 10", {r0_gnt, init_done});
        end
        step();
        r0_req = 1'b0;
        #1;
        checks++;
        if ({init_done, r0_rvalid} !== 2'b11 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL clr_read done/rv=%b rd=%h expected 11 rd=00", {init_done, r0_rvalid}, rd_data);
        end
        step();
    endtask

    task automatic test_clear_restart();
        int n = 0;
        rst = 1'b1; step(); step();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) step();
        #1;
        checks++;
        if (sram_C_addr !== 10'd300) begin
            errors++;
            $display("FAIL rst_at300 addr=%0d expected 300", sram_C_addr);
        end
        rst = 1'b1; step();
        rst = 1'b0;
        #1;
        checks++;
        if (sram_C_addr !== 10'd0 || sram_C_we !== 1'b1) begin
            errors++;
            $display("FAIL restart addr=%0d we=%b expected 0 1", sram_C_addr, sram_C_we);
        end
        while (init_done !== 1'b1 && n < 2100) begin
            step();
            n++;
        end
        checks++;
        if (n != 1025) begin
            errors++;
            $display("FAIL restart_len cycles=%0d expected 1025", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_boundary();
        test_idle_no_update();
        test_reset_mid();
`ifdef SRAM_C_ARB_CLEAR_EN
        test_clear_sweep();
        test_clear_restart();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
